// File: rtl/ahb_master_arbiter_pkg.sv
// Shared AHB-Lite encodings and helpers for the two-master arbiter.
package ahb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011
  } hsize_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// One master's link to the arbiter: request/address/write-data out, grant/response back.
interface ahb_master_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  hbusreq;
  logic                  hmastlock;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hgrant;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic                  hresp;

  modport master (
    output hbusreq, hmastlock, haddr, htrans, hwrite, hsize, hwdata,
    input  hgrant, hrdata, hready, hresp
  );

  modport slave (
    input  hbusreq, hmastlock, haddr, htrans, hwrite, hsize, hwdata,
    output hgrant, hrdata, hready, hresp
  );

endinterface

// File: rtl/ahb_master_arbiter_next_owner.sv
// Combinational next-owner decision: lock, beat-limit yield, and park on the default master.
module ahb_master_arbiter_next_owner
  import ahb_master_arbiter_pkg::*;
#(
  parameter int   MAX_BEATS      = 4,
  parameter int   CNT_W          = 3,
  parameter logic DEFAULT_MASTER = 1'b0
) (
  input  logic             owner,
  input  logic [1:0]       hbusreq,
  input  logic [1:0]       hmastlock,
  input  logic [CNT_W-1:0] beat_cnt,
  input  logic [1:0]       owner_htrans,
  output logic             next_owner
);

  logic own_req;
  logic oth_req;
  logic own_lock;
  logic limit_hit;

  // The beat being accepted this cycle counts toward the limit, so the yield
  // lands exactly after MAX_BEATS address phases.
  always_comb begin
    own_req   = hbusreq[owner];
    oth_req   = hbusreq[~owner];
    own_lock  = hmastlock[owner];
    limit_hit = (int'(beat_cnt) + int'(is_active(owner_htrans))) >= MAX_BEATS;
    next_owner = owner;
    if (own_lock && own_req) begin
      next_owner = owner;
    end else if (oth_req && (!own_req || limit_hit)) begin
      next_owner = ~owner;
    end else if (!own_req && !oth_req) begin
      next_owner = DEFAULT_MASTER;
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter and bus mux; address and data phase owners are tracked separately.
module ahb_master_arbiter
  import ahb_master_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MAX_BEATS      = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_master_arbiter_if.slave   m0,
  ahb_master_arbiter_if.slave   m1,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic                  hmastlock,
  output logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hmaster,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  localparam int   CNT_W     = $clog2(MAX_BEATS + 1);
  localparam logic DEF_OWNER = 1'(DEFAULT_MASTER);

  logic             addr_owner;
  logic             data_owner;
  logic             data_active;
  logic [CNT_W-1:0] beat_cnt;
  logic             next_owner;

  ahb_master_arbiter_next_owner #(
    .MAX_BEATS      (MAX_BEATS),
    .CNT_W          (CNT_W),
    .DEFAULT_MASTER (DEF_OWNER)
  ) u_next_owner (
    .owner        (addr_owner),
    .hbusreq      ({m1.hbusreq, m0.hbusreq}),
    .hmastlock    ({m1.hmastlock, m0.hmastlock}),
    .beat_cnt     (beat_cnt),
    .owner_htrans (htrans),
    .next_owner   (next_owner)
  );

  // Everything advances only on hready, so a wait state freezes grant and data routing together.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_owner  <= DEF_OWNER;
      data_owner  <= DEF_OWNER;
      data_active <= 1'b0;
      beat_cnt    <= '0;
    end else if (hready) begin
      addr_owner  <= next_owner;
      data_owner  <= addr_owner;
      data_active <= is_active(htrans);
      if (next_owner != addr_owner) begin
        beat_cnt <= '0;
      end else if (is_active(htrans) && (beat_cnt != CNT_W'(MAX_BEATS))) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // Address phase follows the address owner, write data follows whoever owns the data phase.
  always_comb begin
    haddr     = m0.haddr;
    htrans    = m0.htrans;
    hwrite    = m0.hwrite;
    hsize     = m0.hsize;
    hmastlock = m0.hmastlock;
    if (addr_owner) begin
      haddr     = m1.haddr;
      htrans    = m1.htrans;
      hwrite    = m1.hwrite;
      hsize     = m1.hsize;
      hmastlock = m1.hmastlock;
    end
    hwdata  = data_owner ? m1.hwdata : m0.hwdata;
    hmaster = addr_owner;

    m0.hgrant = !addr_owner;
    m1.hgrant = addr_owner;
    m0.hrdata = hrdata;
    m1.hrdata = hrdata;
    m0.hready = hready;
    m1.hready = hready;
    m0.hresp  = (data_active && !data_owner) ? hresp : HRESP_OKAY;
    m1.hresp  = (data_active &&  data_owner) ? hresp : HRESP_OKAY;
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: two simple burst masters and a scripted slave.
module tb_ahb_master_arbiter;
  import ahb_master_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic          hmastlock;
  logic [DW-1:0] hwdata;
  logic          hmaster;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic          hresp;

  always #5 HCLK = ~HCLK;

  ahb_master_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_bus ();
  ahb_master_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_bus ();

  ahb_master_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BEATS(4), .DEFAULT_MASTER(0)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .m0(m0_bus), .m1(m1_bus),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hmastlock(hmastlock), .hwdata(hwdata), .hmaster(hmaster),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  int checks = 0;
  int errors = 0;

  // Per-master burst model state
  int            rem [2];
  int            issued [2];
  logic [AW-1:0] base [2];
  logic [DW-1:0] dbase [2];
  logic          lock_req [2];
  logic          acc [2];
  logic [1:0]    tr [2];
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];
  logic          rdy_prev;
  logic          dp_valid;

  logic          acc_mst_q [$];
  logic [AW-1:0] acc_addr_q [$];
  logic [DW-1:0] wd_q [$];

  task automatic apply();
    m0_bus.hbusreq = rem[0] > 0;  m1_bus.hbusreq = rem[1] > 0;
    m0_bus.hmastlock = lock_req[0] && (rem[0] > 0);
    m1_bus.hmastlock = lock_req[1] && (rem[1] > 0);
    m0_bus.htrans = tr[0];  m1_bus.htrans = tr[1];
    m0_bus.haddr  = ad[0];  m1_bus.haddr  = ad[1];
    m0_bus.hwdata = wd[0];  m1_bus.hwdata = wd[1];
    m0_bus.hwrite = 1'b1;   m1_bus.hwrite = 1'b1;
    m0_bus.hsize  = HSIZE_WORD;  m1_bus.hsize = HSIZE_WORD;
  endtask

  task automatic reset_model();
    for (int m = 0; m < 2; m++) begin
      rem[m] = 0; issued[m] = 0; base[m] = '0; dbase[m] = '0; lock_req[m] = 1'b0;
      acc[m] = 1'b0; tr[m] = HTRANS_IDLE; ad[m] = '0; wd[m] = '0;
    end
    rdy_prev = 1'b1;
    dp_valid = 1'b0;
    apply();
  endtask

  task automatic clear_logs();
    acc_mst_q.delete(); acc_addr_q.delete(); wd_q.delete();
  endtask

  task automatic start_burst(input int m, input int n, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic lk);
    rem[m] = n; issued[m] = 0; base[m] = a; dbase[m] = d; lock_req[m] = lk;
  endtask

  // One bus cycle: masters react to grant after the edge, bus is observed at the falling edge.
  task automatic step(input logic rdy, input logic rsp);
    logic g [2];
    @(posedge HCLK); #1;
    g[0] = m0_bus.hgrant; g[1] = m1_bus.hgrant;
    for (int m = 0; m < 2; m++) begin
      if (rdy_prev) begin
        if (acc[m]) begin
          issued[m]++; rem[m]--;
          wd[m] = dbase[m] + DW'(issued[m] - 1);
        end
        if (g[m] && rem[m] > 0) begin
          tr[m] = acc[m] ? HTRANS_SEQ : HTRANS_NONSEQ;
          ad[m] = base[m] + AW'(4 * issued[m]);
        end else begin
          tr[m] = HTRANS_IDLE;
        end
      end
    end
    apply();
    hready = rdy; hresp = rsp;
    @(negedge HCLK);
    if (hready) begin
      if (dp_valid) wd_q.push_back(hwdata);
      dp_valid = htrans[1];
      if (htrans[1]) begin
        acc_mst_q.push_back(hmaster); acc_addr_q.push_back(haddr);
      end
    end
    for (int m = 0; m < 2; m++) acc[m] = hready && tr[m][1];
    rdy_prev = hready;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (m0_bus.hgrant !== 1'b1) begin errors++; $display("[TB] FAIL rst_m0_hgrant got=%0h exp=1", m0_bus.hgrant); end
    checks++; if (m1_bus.hgrant !== 1'b0) begin errors++; $display("[TB] FAIL rst_m1_hgrant got=%0h exp=0", m1_bus.hgrant); end
    checks++; if (hmaster !== 1'b0) begin errors++; $display("[TB] FAIL rst_hmaster got=%0h exp=0", hmaster); end
    checks++; if (m0_bus.hresp !== 1'b0 || m1_bus.hresp !== 1'b0) begin errors++; $display("[TB] FAIL rst_hresp got=%0h/%0h exp=0/0", m0_bus.hresp, m1_bus.hresp); end
    @(negedge HCLK); HRESETn = 1'b1; hresp = 1'b0;
    clear_logs();
    start_burst(1, 8, 32'h500, 32'h5000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    checks++; if (m1_bus.hgrant !== 1'b1) begin errors++; $display("[TB] FAIL midburst_m1_hgrant got=%0h exp=1", m1_bus.hgrant); end
    checks++; if (htrans !== HTRANS_SEQ) begin errors++; $display("[TB] FAIL midburst_htrans got=%0h exp=3", htrans); end
    hresp = 1'b1; HRESETn = 1'b0; #1;
    checks++; if (m0_bus.hgrant !== 1'b1 || m1_bus.hgrant !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_hgrant got=%0h/%0h exp=1/0", m0_bus.hgrant, m1_bus.hgrant); end
    checks++; if (hmaster !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_hmaster got=%0h exp=0", hmaster); end
    checks++; if (htrans !== HTRANS_IDLE) begin errors++; $display("[TB] FAIL async_rst_htrans got=%0h exp=0", htrans); end
    checks++; if (m0_bus.hresp !== 1'b0 || m1_bus.hresp !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_hresp got=%0h/%0h exp=0/0", m0_bus.hresp, m1_bus.hresp); end
    reset_model(); hresp = 1'b0;
    @(negedge HCLK); HRESETn = 1'b1;
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    checks++; if (m0_bus.hgrant !== 1'b1) begin errors++; $display("[TB] FAIL park_m0_hgrant got=%0h exp=1", m0_bus.hgrant); end
  endtask

  task automatic test_contention();
    int n = 0;
    clear_logs();
    start_burst(0, 8, 32'h100, 32'h1000, 1'b0);
    start_burst(1, 8, 32'h200, 32'h2000, 1'b0);
    while ((rem[0] > 0 || rem[1] > 0) && n < 60) begin step(1'b1, 1'b0); n++; end
    repeat (3) step(1'b1, 1'b0);
    checks++; if (n >= 60) begin errors++; $display("[TB] FAIL contention_timeout got=%0d exp<60", n); end
    checks++;
    if (acc_mst_q.size() != 16 || wd_q.size() != 16) begin
      errors++; $display("[TB] FAIL contention_beats got=%0d/%0d exp=16/16", acc_mst_q.size(), wd_q.size());
    end else begin
      // Grants alternate in groups of four: m0 0-3, m1 0-3, m0 4-7, m1 4-7.
      for (int i = 0; i < 16; i++) begin
        logic em; int k; logic [AW-1:0] ea; logic [DW-1:0] ed;
        em = 1'((i / 4) % 2);
        k  = ((i / 4) / 2) * 4 + (i % 4);
        ea = (em ? 32'h200 : 32'h100) + AW'(4 * k);
        ed = (em ? 32'h2000 : 32'h1000) + DW'(k);
        checks++; if (acc_mst_q[i] !== em || acc_addr_q[i] !== ea) begin errors++; $display("[TB] FAIL contention_addr[%0d] got=m%0h@%0h exp=m%0h@%0h", i, acc_mst_q[i], acc_addr_q[i], em, ea); end
        checks++; if (wd_q[i] !== ed) begin errors++; $display("[TB] FAIL contention_wdata[%0d] got=%0h exp=%0h", i, wd_q[i], ed); end
      end
    end
  endtask

  task automatic test_lock();
    int n = 0;
    int early = 0;
    clear_logs();
    start_burst(0, 6, 32'h600, 32'h6000, 1'b1);
    start_burst(1, 2, 32'h700, 32'h7000, 1'b0);
    step(1'b1, 1'b0); n++;
    checks++; if (hmastlock !== 1'b1) begin errors++; $display("[TB] FAIL lock_hmastlock got=%0h exp=1", hmastlock); end
    while ((rem[0] > 0 || rem[1] > 0) && n < 40) begin
      step(1'b1, 1'b0); n++;
      if (rem[0] > 0 && m1_bus.hgrant === 1'b1) early++;
    end
    repeat (3) step(1'b1, 1'b0);
    checks++; if (early != 0) begin errors++; $display("[TB] FAIL lock_m1_early_grant got=%0d exp=0", early); end
    checks++;
    if (acc_mst_q.size() != 8) begin
      errors++; $display("[TB] FAIL lock_beats got=%0d exp=8", acc_mst_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic em; logic [AW-1:0] ea;
        em = (i >= 6);
        ea = em ? 32'h700 + AW'(4 * (i - 6)) : 32'h600 + AW'(4 * i);
        checks++; if (acc_mst_q[i] !== em || acc_addr_q[i] !== ea) begin errors++; $display("[TB] FAIL lock_order[%0d] got=m%0h@%0h exp=m%0h@%0h", i, acc_mst_q[i], acc_addr_q[i], em, ea); end
      end
    end
  endtask

  task automatic test_wait_states();
    logic rdy_pat [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [DW-1:0] exp_wd [4] = '{32'h3000, 32'h3001, 32'h4000, 32'h4001};
    clear_logs();
    start_burst(0, 2, 32'h300, 32'h3000, 1'b0);
    start_burst(1, 2, 32'h400, 32'h4000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(rdy_pat[i], 1'b0);
      if (i >= 2 && i <= 4) begin
        checks++; if (m0_bus.hgrant !== 1'b1 || m1_bus.hgrant !== 1'b0) begin errors++; $display("[TB] FAIL wait_hgrant[%0d] got=%0h/%0h exp=1/0", i, m0_bus.hgrant, m1_bus.hgrant); end
        checks++; if (hwdata !== 32'h3001) begin errors++; $display("[TB] FAIL wait_hwdata[%0d] got=%0h exp=3001", i, hwdata); end
        checks++; if (m0_bus.hready !== 1'b0 || m1_bus.hready !== 1'b0) begin errors++; $display("[TB] FAIL wait_hready[%0d] got=%0h/%0h exp=0/0", i, m0_bus.hready, m1_bus.hready); end
      end
      if (i == 6) begin
        checks++; if (m1_bus.hgrant !== 1'b1 || hmaster !== 1'b1) begin errors++; $display("[TB] FAIL wait_handover got=%0h/%0h exp=1/1", m1_bus.hgrant, hmaster); end
      end
    end
    checks++;
    if (wd_q.size() != 4) begin
      errors++; $display("[TB] FAIL wait_beats got=%0d exp=4", wd_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (wd_q[i] !== exp_wd[i]) begin errors++; $display("[TB] FAIL wait_wdata[%0d] got=%0h exp=%0h", i, wd_q[i], exp_wd[i]); end
      end
    end
  endtask

  task automatic test_error();
    clear_logs();
    start_burst(1, 1, 32'h0, 32'hDEAD, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++; if (haddr !== 32'h0 || hmaster !== 1'b1 || htrans !== HTRANS_NONSEQ) begin errors++; $display("[TB] FAIL err_addr got=%0h/m%0h/%0h exp=0/m1/2", haddr, hmaster, htrans); end
    step(1'b0, 1'b1);
    checks++; if (m1_bus.hresp !== 1'b1 || m0_bus.hresp !== 1'b0) begin errors++; $display("[TB] FAIL err_cycle1 got=%0h/%0h exp=1/0", m1_bus.hresp, m0_bus.hresp); end
    step(1'b1, 1'b1);
    checks++; if (m1_bus.hresp !== 1'b1 || m0_bus.hresp !== 1'b0) begin errors++; $display("[TB] FAIL err_cycle2 got=%0h/%0h exp=1/0", m1_bus.hresp, m0_bus.hresp); end
    step(1'b1, 1'b0);
    checks++; if (m1_bus.hresp !== 1'b0 || m0_bus.hgrant !== 1'b1) begin errors++; $display("[TB] FAIL err_after got=%0h/%0h exp=0/1", m1_bus.hresp, m0_bus.hgrant); end
  endtask

  task automatic test_solo();
    clear_logs();
    start_burst(0, 1, 32'h4, 32'hAA, 1'b0);
    step(1'b1, 1'b0);
    checks++; if (haddr !== 32'h4 || htrans !== HTRANS_NONSEQ || hwrite !== 1'b1 || hmaster !== 1'b0) begin errors++; $display("[TB] FAIL solo_addr got=%0h/%0h/%0h/m%0h exp=4/2/1/m0", haddr, htrans, hwrite, hmaster); end
    step(1'b1, 1'b0);
    checks++; if (hwdata !== 32'hAA) begin errors++; $display("[TB] FAIL solo_hwdata got=%0h exp=aa", hwdata); end
    checks++; if (m0_bus.hrdata !== 32'h1234_5678 || m1_bus.hrdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL solo_hrdata got=%0h/%0h exp=12345678", m0_bus.hrdata, m1_bus.hrdata); end
    step(1'b1, 1'b0);
  endtask

  initial begin
    HRESETn = 1'b0;
    hready  = 1'b1;
    hresp   = 1'b1;
    hrdata  = 32'h1234_5678;
    reset_model();
    test_reset();
    test_contention();
    test_lock();
    test_wait_states();
    test_error();
    test_solo();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
